cordic_ctrl: RTL and testbench
==============================

# cordic_ctrl

Iterative sequencer that sits directly upstream of the single CORDIC micro-rotation stage and turns it into a complete sin/cos engine. It accepts one angle per transaction over a valid/ready handshake, folds it into the convergence range, and seeds x/y/z. It then drives the stage through N_ITERATIONS rotations, supplying alpha from an internal arctangent ROM and feeding each stage result back as the next input. It presents the unfolded cos/sin result over a second valid/ready handshake.

## Interface
- WORD_LENGTH, 21, signed fixed-point word width, format Q4.16 (1 sign, 4 integer, 16 fraction bits)
- N_ITERATIONS, 17, rotations per transaction (1..17)
- STAGE_LATENCY, 1, clock cycles from stage inputs to valid stage outputs (1..4)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  angle available
- in_ready_o  out  1  high only in IDLE
- theta_i  in  WORD_LENGTH  angle in radians, Q4.16
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer accepts result
- cos_o  out  WORD_LENGTH  cosine, Q4.16
- sin_o  out  WORD_LENGTH  sine, Q4.16
- stage_x_o / stage_y_o / stage_z_o  out  WORD_LENGTH each  current x/y/z to stage
- stage_alpha_o  out  WORD_LENGTH  atan(2^-k) for current iteration k
- stage_iter_o  out  5  current iteration index k
- stage_next_x_i / stage_next_y_i / stage_next_z_i  in  WORD_LENGTH each  stage results

## Operation
- **Reset (rst low):**
  - State IDLE; all registers 0.
  - out_valid_o=0, cos_o=sin_o=0.
  - stage_* outputs 0.
  - in_ready_o=1. Handshakes are ignored while rst is low.
- **States:**
  - IDLE: on in_valid_i & in_ready_o, load working registers and go to ITER.
  - ITER: run N_ITERATIONS rotations, then go to DONE.
  - DONE: on out_valid_o & out_ready_i, go to IDLE.
- **Load, applied to the accepted theta:**
  - Clamp theta to [-205887, 205887] (±π).
  - If theta > 102944 (π/2): z = theta − 205887, neg = 1.
  - If theta < −102944: z = theta + 205887, neg = 1.
  - Otherwise: z = theta, neg = 0.
  - x = 39797 (gain constant K = 0.6072529), y = 0, k = 0.
- **ITER:**
  - Working x/y/z and k are driven onto the stage_* ports and held stable for STAGE_LATENCY cycles.
  - On the last of those cycles, stage_next_* are captured into x/y/z and k increments.
  - After capture of iteration N_ITERATIONS−1: cos_o = neg ? −x : x, sin_o = neg ? −y : y. Then go to DONE.
- **Alpha ROM, k = 0..16:** 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1. Entries for k ≥ 17 read 0.
- **Arithmetic:**
  - All values are two's complement, WORD_LENGTH bits.
  - Negation cannot overflow, since |result| ≤ 65600.
  - Clamping compares the full signed word.

## Timing
- Accept edge = cycle 0.
- Iteration k inputs are presented in cycles 1+k·L .. (k+1)·L, where L = STAGE_LATENCY.
- out_valid_o is first high in cycle N_ITERATIONS·L + 1. Defaults give 18 cycles accept-to-valid.
- **Output hold:**
  - cos_o/sin_o/out_valid_o stay stable until the handshake completes.
  - out_valid_o drops the cycle after the handshake.
- **No bypass:** in_ready_o rises the cycle after the output handshake, so throughput is one transaction per N·L+2 cycles.
- in_valid_i is ignored outside IDLE.
- stage_* outputs keep their last values in DONE and IDLE.
- **Reset mid-operation:**
  - Immediately returns to IDLE and drops out_valid_o.
  - The partial transaction is discarded, with no output.

## Test plan
- **theta = 0, out_ready_i = 1, real stage, defaults:**
  - out_valid_o high exactly 18 cycles after accept.
  - cos_o = 65536 ±8, sin_o = 0 ±8.
  - in_ready_o high the cycle after.
- **theta = 51472 (π/4):** cos_o = 46341 ±8, sin_o = 46341 ±8. stage_alpha_o sequence matches the ROM, stage_iter_o runs 0..16.
- **Folding:**
  - theta = 205887 (π): cos_o = −65536 ±8, sin_o = 0 ±8.
  - theta = −154415 (−3π/4): cos_o = sin_o = −46341 ±8.
  - theta = 300000: same result as π (clamped).
- **Backpressure:**
  - Hold out_ready_i = 0 for 10 cycles after out_valid_o, while toggling in_valid_i with new angles.
  - Outputs remain stable, in_ready_o stays 0, no new angle is accepted.
  - After the handshake, the next angle is accepted.
- **Reset mid-iteration:**
  - Assert rst low asynchronously during iteration 8.
  - out_valid_o = 0 and cos_o = sin_o = 0 immediately. After release, in_ready_o = 1.
  - A new transaction with theta = 0 completes correctly.
- **STAGE_LATENCY = 3:** each stage_iter_o value is held 3 cycles, out_valid_o is high at cycle 52, and results match the latency-1 run.

Source files
------------

// File: rtl/cordic_ctrl.sv
// cordic_ctrl
// Sequencer that wraps one external CORDIC micro-rotation stage into a full
// sin/cos engine. An angle is accepted, folded into the convergence range and
// seeded as x/y/z. The stage is then driven for N_ITERATIONS rotations with
// alpha taken from an internal arctangent ROM. Each stage result is fed back
// as the next input, and the unfolded cos/sin result is presented on output.
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o        angle handshake (in_ready_o high only in IDLE)
//   theta_i                      angle in radians, signed Q4.16
//   out_valid_o/out_ready_i      result handshake
//   cos_o, sin_o                 result, signed Q4.16
//   stage_x_o/_y_o/_z_o          working values presented to the stage
//   stage_alpha_o, stage_iter_o  atan(2^-k) and k for the current rotation
//   stage_next_x_i/_y_i/_z_i     stage results
//   state_o                      FSM state (0 IDLE, 1 ITER, 2 DONE) for debug
//
// Handshake rule (both ports): a transfer happens on a rising edge where valid
// and ready are both high. A producer holding valid keeps its data stable
// until that edge. Valid never waits on ready.
module cordic_ctrl #(
    parameter int WORD_LENGTH   = 21,
    parameter int N_ITERATIONS  = 17,
    parameter int STAGE_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WORD_LENGTH-1:0] theta_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WORD_LENGTH-1:0] cos_o,
    output logic [WORD_LENGTH-1:0] sin_o,
    output logic [WORD_LENGTH-1:0] stage_x_o,
    output logic [WORD_LENGTH-1:0] stage_y_o,
    output logic [WORD_LENGTH-1:0] stage_z_o,
    output logic [WORD_LENGTH-1:0] stage_alpha_o,
    output logic [4:0]             stage_iter_o,
    input  logic [WORD_LENGTH-1:0] stage_next_x_i,
    input  logic [WORD_LENGTH-1:0] stage_next_y_i,
    input  logic [WORD_LENGTH-1:0] stage_next_z_i,
    output logic [1:0]             state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [WORD_LENGTH-1:0] PI_Q       = WORD_LENGTH'(205887);
    localparam logic signed [WORD_LENGTH-1:0] NEG_PI_Q   = -PI_Q;
    localparam logic signed [WORD_LENGTH-1:0] HALF_PI_Q  = WORD_LENGTH'(102944);
    localparam logic signed [WORD_LENGTH-1:0] NEG_HALF_Q = -HALF_PI_Q;
    localparam logic signed [WORD_LENGTH-1:0] K_GAIN     = WORD_LENGTH'(39797);
    localparam logic [1:0] LAT_LAST = 2'(STAGE_LATENCY - 1);
    localparam logic [4:0] K_LAST   = 5'(N_ITERATIONS - 1);

    function automatic logic signed [WORD_LENGTH-1:0] atan_rom(input logic [4:0] k);
        case (k)
            5'd0:    atan_rom = WORD_LENGTH'(51472);
            5'd1:    atan_rom = WORD_LENGTH'(30386);
            5'd2:    atan_rom = WORD_LENGTH'(16055);
            5'd3:    atan_rom = WORD_LENGTH'(8150);
            5'd4:    atan_rom = WORD_LENGTH'(4091);
            5'd5:    atan_rom = WORD_LENGTH'(2047);
            5'd6:    atan_rom = WORD_LENGTH'(1024);
            5'd7:    atan_rom = WORD_LENGTH'(512);
            5'd8:    atan_rom = WORD_LENGTH'(256);
            5'd9:    atan_rom = WORD_LENGTH'(128);
            5'd10:   atan_rom = WORD_LENGTH'(64);
            5'd11:   atan_rom = WORD_LENGTH'(32);
            5'd12:   atan_rom = WORD_LENGTH'(16);
            5'd13:   atan_rom = WORD_LENGTH'(8);
            5'd14:   atan_rom = WORD_LENGTH'(4);
            5'd15:   atan_rom = WORD_LENGTH'(2);
            5'd16:   atan_rom = WORD_LENGTH'(1);
            default: atan_rom = '0;
        endcase
    endfunction

    state_t state_q, state_d;

    logic signed [WORD_LENGTH-1:0] x_q, y_q, z_q, alpha_q, cos_q, sin_q;
    logic [4:0] k_q;
    logic [1:0] lat_q;
    logic       neg_q;

    logic accept, capture, last_capture;

    logic signed [WORD_LENGTH-1:0] theta_s, theta_c, z_load;
    logic signed [WORD_LENGTH-1:0] nx_s, ny_s, nz_s;
    logic neg_load;

    assign theta_s = $signed(theta_i);
    assign nx_s    = $signed(stage_next_x_i);
    assign ny_s    = $signed(stage_next_y_i);
    assign nz_s    = $signed(stage_next_z_i);

    // Clamp to +/-pi, then fold the outer half-planes by pi. The fold is
    // undone at the end by negating both results.
    always_comb begin
        theta_c  = theta_s;
        z_load   = theta_s;
        neg_load = 1'b0;
        if (theta_s > PI_Q) begin
            theta_c = PI_Q;
        end else if (theta_s < NEG_PI_Q) begin
            theta_c = NEG_PI_Q;
        end
        z_load = theta_c;
        if (theta_c > HALF_PI_Q) begin
            z_load   = theta_c - PI_Q;
            neg_load = 1'b1;
        end else if (theta_c < NEG_HALF_Q) begin
            z_load   = theta_c + PI_Q;
            neg_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        capture      = 1'b0;
        last_capture = 1'b0;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    accept  = 1'b1;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                // Stage inputs are held for STAGE_LATENCY cycles; capture on the last.
                if (lat_q == LAT_LAST) begin
                    capture = 1'b1;
                    if (k_q == K_LAST) begin
                        last_capture = 1'b1;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            alpha_q <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            k_q     <= '0;
            lat_q   <= '0;
            neg_q   <= 1'b0;
        end else if (accept) begin
            x_q     <= K_GAIN;
            y_q     <= '0;
            z_q     <= z_load;
            neg_q   <= neg_load;
            k_q     <= '0;
            lat_q   <= '0;
            alpha_q <= atan_rom(5'd0);
        end else if (state_q == S_ITER) begin
            if (capture) begin
                lat_q <= '0;
                if (last_capture) begin
                    // Take the result straight from the stage so the stage-facing
                    // registers keep the last rotation's inputs through DONE/IDLE.
                    cos_q <= neg_q ? -nx_s : nx_s;
                    sin_q <= neg_q ? -ny_s : ny_s;
                end else begin
                    x_q     <= nx_s;
                    y_q     <= ny_s;
                    z_q     <= nz_s;
                    k_q     <= k_q + 5'd1;
                    alpha_q <= atan_rom(k_q + 5'd1);
                end
            end else begin
                lat_q <= lat_q + 2'd1;
            end
        end
    end

    assign cos_o         = cos_q;
    assign sin_o         = sin_q;
    assign stage_x_o     = x_q;
    assign stage_y_o     = y_q;
    assign stage_z_o     = z_q;
    assign stage_alpha_o = alpha_q;
    assign stage_iter_o  = k_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_cordic_ctrl.sv
// Bench for cordic_ctrl. Instance 0 runs with a 1-cycle stage, instance 1
// with a 3-cycle stage; each has its own behavioural micro-rotation stage.
module tb_cordic_ctrl;
    localparam int W = 21;
    localparam int N = 17;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                in_valid  [2];
    logic                in_ready  [2];
    logic                out_valid [2];
    logic                out_ready [2];
    logic [W-1:0]        theta     [2];
    logic signed [W-1:0] cos_v     [2];
    logic signed [W-1:0] sin_v     [2];
    logic signed [W-1:0] sx        [2];
    logic signed [W-1:0] sy        [2];
    logic signed [W-1:0] sz        [2];
    logic signed [W-1:0] salpha    [2];
    logic [4:0]          siter     [2];
    logic [1:0]          st        [2];

    int rom_tab [17] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256,
                         128, 64, 32, 16, 8, 4, 2, 1};

    int n_checks = 0;
    int n_fail   = 0;
    int iter_log  [256];
    int alpha_log [256];
    int log_len;
    logic [63:0] exp_q [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic signed [W-1:0] cx, cy, cz;
        logic signed [W-1:0] px [2];
        logic signed [W-1:0] py [2];
        logic signed [W-1:0] pz [2];
        logic [W-1:0] nx, ny, nz;

        // One micro-rotation: direction from the sign of z.
        always_comb begin
            if (!sz[g][W-1]) begin
                cx = sx[g] - (sy[g] >>> siter[g]);
                cy = sy[g] + (sx[g] >>> siter[g]);
                cz = sz[g] - salpha[g];
            end else begin
                cx = sx[g] + (sy[g] >>> siter[g]);
                cy = sy[g] - (sx[g] >>> siter[g]);
                cz = sz[g] + salpha[g];
            end
        end

        always @(posedge clk) begin
            px[0] <= cx; px[1] <= px[0];
            py[0] <= cy; py[1] <= py[0];
            pz[0] <= cz; pz[1] <= pz[0];
        end

        assign nx = (LAT == 1) ? cx : px[(LAT >= 2) ? LAT - 2 : 0];
        assign ny = (LAT == 1) ? cy : py[(LAT >= 2) ? LAT - 2 : 0];
        assign nz = (LAT == 1) ? cz : pz[(LAT >= 2) ? LAT - 2 : 0];

        cordic_ctrl #(
            .WORD_LENGTH  (W),
            .N_ITERATIONS (N),
            .STAGE_LATENCY(LAT)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .in_valid_i    (in_valid[g]),
            .in_ready_o    (in_ready[g]),
            .theta_i       (theta[g]),
            .out_valid_o   (out_valid[g]),
            .out_ready_i   (out_ready[g]),
            .cos_o         (cos_v[g]),
            .sin_o         (sin_v[g]),
            .stage_x_o     (sx[g]),
            .stage_y_o     (sy[g]),
            .stage_z_o     (sz[g]),
            .stage_alpha_o (salpha[g]),
            .stage_iter_o  (siter[g]),
            .stage_next_x_i(nx),
            .stage_next_y_i(ny),
            .stage_next_z_i(nz),
            .state_o       (st[g])
        );
    end

    // Reference: clamp, fold, 17 CORDIC rotations on plain integers, unfold.
    function automatic void ref_cordic(input int th, output int c, output int s);
        int t, x, y, z, xn;
        bit neg;
        t = th;
        if (t > 205887) t = 205887;
        if (t < -205887) t = -205887;
        if (t > 102944) begin z = t - 205887; neg = 1'b1; end
        else if (t < -102944) begin z = t + 205887; neg = 1'b1; end
        else begin z = t; neg = 1'b0; end
        x = 39797;
        y = 0;
        for (int k = 0; k < N; k++) begin
            if (z >= 0) begin
                xn = x - (y >>> k); y = y + (x >>> k); z = z - rom_tab[k];
            end else begin
                xn = x + (y >>> k); y = y - (x >>> k); z = z + rom_tab[k];
            end
            x = xn;
        end
        c = neg ? -x : x;
        s = neg ? -y : y;
    endfunction

    task automatic check_eq(input string name, input logic signed [31:0] act,
                            input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        int d;
        n_checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // One full transaction; hold = cycles out_ready stays low after out_valid,
    // during which in_valid is toggled with junk angles.
    task automatic run_txn(input int idx, input int th, input int hold,
                           output int c, output int s, output int lat);
        int n;
        c = 0; s = 0; lat = -1;
        @(negedge clk);
        n = 0;
        while (!in_ready[idx] && n < 100) begin @(negedge clk); n++; end
        if (!in_ready[idx]) begin report_timeout("accept"); return; end
        in_valid[idx]  = 1'b1;
        theta[idx]     = W'(th);
        out_ready[idx] = 1'b0;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        log_len = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (log_len < 256) begin
                iter_log[log_len]  = int'(siter[idx]);
                alpha_log[log_len] = int'(salpha[idx]);
                log_len++;
            end
        end while (!out_valid[idx] && n < 300);
        if (!out_valid[idx]) begin report_timeout("result"); return; end
        lat = n;
        c = int'(cos_v[idx]);
        s = int'(sin_v[idx]);
        for (int i = 0; i < hold; i++) begin
            in_valid[idx] = i[0];
            theta[idx]    = W'($urandom_range(0, 200000));
            @(negedge clk);
            check_eq("hold_valid", out_valid[idx], 1);
            check_eq("hold_cos", cos_v[idx], c);
            check_eq("hold_sin", sin_v[idx], s);
            check_eq("hold_in_ready", in_ready[idx], 0);
        end
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready[idx] = 1'b0;
        @(negedge clk);
        check_eq("valid_drop", out_valid[idx], 0);
        check_eq("ready_rise", in_ready[idx], 1);
    endtask

    typedef struct {
        int theta;
        int exp_cos;
        int exp_sin;
        bit chk_seq;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int c, s, lat, rc, rs, n, bad, c_pi4, s_pi4, idx, th;
        int bnd [8];
        logic [63:0] e;

        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; theta[i] = '0;
        end

        vecs[0] = '{0,       65536,  0,      1'b0};
        vecs[1] = '{51472,   46341,  46341,  1'b1};
        vecs[2] = '{205887, -65536,  0,      1'b0};
        vecs[3] = '{-154415, -46341, -46341, 1'b0};
        vecs[4] = '{300000, -65536,  0,      1'b0};
        vecs[5] = '{-300000, -65536, 0,      1'b0};
        bnd = '{102944, 102945, -102944, -102945, 205887, 205888, -205887, -205888};
        c_pi4 = 0; s_pi4 = 0;

        // Reset state
        #12;
        check_eq("rst_in_ready", in_ready[0], 1);
        check_eq("rst_out_valid", out_valid[0], 0);
        check_eq("rst_cos", cos_v[0], 0);
        check_eq("rst_sin", sin_v[0], 0);
        check_eq("rst_stage_x", sx[0], 0);
        check_eq("rst_stage_y", sy[0], 0);
        check_eq("rst_stage_z", sz[0], 0);
        check_eq("rst_stage_alpha", salpha[0], 0);
        check_eq("rst_stage_iter", siter[0], 0);
        check_eq("rst_state", st[0], 0);
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ignores_valid", st[0], 0);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors, latency 1
        for (int v = 0; v < 6; v++) begin
            run_txn(0, vecs[v].theta, 0, c, s, lat);
            ref_cordic(vecs[v].theta, rc, rs);
            check_eq("vec_latency", lat, 18);
            check_tol("vec_cos_approx", c, vecs[v].exp_cos, 8);
            check_tol("vec_sin_approx", s, vecs[v].exp_sin, 8);
            check_eq("vec_cos_exact", c, rc);
            check_eq("vec_sin_exact", s, rs);
            if (vecs[v].chk_seq) begin
                c_pi4 = c; s_pi4 = s;
                for (int k = 0; k < N; k++) begin
                    check_eq("seq_iter", iter_log[k], k);
                    check_eq("seq_alpha", alpha_log[k], rom_tab[k]);
                end
            end
        end

        // Stage latency 3
        run_txn(1, 51472, 0, c, s, lat);
        check_eq("l3_latency", lat, 52);
        bad = 0;
        for (int i = 0; i < 51; i++) if (iter_log[i] != i / 3) bad++;
        check_eq("l3_iter_hold", bad, 0);
        check_eq("l3_cos_match", c, c_pi4);
        check_eq("l3_sin_match", s, s_pi4);

        // Backpressure with junk angles offered, then a fresh angle
        run_txn(0, 80000, 10, c, s, lat);
        ref_cordic(80000, rc, rs);
        check_eq("bp_cos", c, rc);
        check_eq("bp_sin", s, rs);
        run_txn(0, -60000, 0, c, s, lat);
        ref_cordic(-60000, rc, rs);
        check_eq("bp_next_cos", c, rc);
        check_eq("bp_next_sin", s, rs);

        // Reset during iteration 8
        @(negedge clk);
        in_valid[0] = 1'b1; theta[0] = W'(100000); out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (siter[0] != 5'd8 && n < 50);
        check_eq("rst_mid_reached_k8", siter[0], 8);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_mid_valid", out_valid[0], 0);
        check_eq("rst_mid_cos", cos_v[0], 0);
        check_eq("rst_mid_sin", sin_v[0], 0);
        check_eq("rst_mid_state", st[0], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_ready", in_ready[0], 1);

        // Reset while a result is waiting
        in_valid[0] = 1'b1; theta[0] = W'(40000); out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid[0] && n < 50);
        check_eq("rst_done_valid_before", out_valid[0], 1);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_done_valid", out_valid[0], 0);
        check_eq("rst_done_cos", cos_v[0], 0);
        check_eq("rst_done_sin", sin_v[0], 0);
        @(negedge clk);
        rst = 1'b1;
        run_txn(0, 0, 0, c, s, lat);
        check_eq("after_rst_latency", lat, 18);
        check_tol("after_rst_cos", c, 65536, 8);
        check_tol("after_rst_sin", s, 0, 8);

        // Random and boundary angles through both instances
        for (int t = 0; t < 28; t++) begin
            th  = (t < 8) ? bnd[t] : (int'($urandom_range(0, 600000)) - 300000);
            idx = int'($urandom_range(0, 1));
            ref_cordic(th, rc, rs);
            exp_q.push_back({rc, rs});
            run_txn(idx, th, int'($urandom_range(0, 3)), c, s, lat);
            e = exp_q.pop_front();
            check_eq("rnd_latency", lat, (idx == 0) ? 18 : 52);
            check_eq("rnd_cos", c, e[63:32]);
            check_eq("rnd_sin", s, e[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
